// File: rtl/alarm_bank.sv
// Bank of NUM_ALARMS BCD HH:MM alarm slots with per-slot ring/ack FSM; define ALARM_SNOOZE_EN to add snooze.
// Latency: alarm_ringing rises one cycle after a match; load_err one cycle after the load; readback combinational.
// Backpressure: none; invalid or out-of-range loads are dropped and flagged with a one-cycle load_err pulse.
module alarm_bank #(
    parameter int NUM_ALARMS = 4,
    parameter int SEL_W      = 2,
    parameter int SNOOZE_MIN = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3:0]            new_alarm_ms_hr,
    input  logic [3:0]            new_alarm_ls_hr,
    input  logic [3:0]            new_alarm_ms_min,
    input  logic [3:0]            new_alarm_ls_min,
    input  logic [SEL_W-1:0]      slot_sel,
    input  logic                  load_new_alarm,
    input  logic                  clear_alarm,
    input  logic [3:0]            current_time_ms_hr,
    input  logic [3:0]            current_time_ls_hr,
    input  logic [3:0]            current_time_ms_min,
    input  logic [3:0]            current_time_ls_min,
    input  logic                  alarm_ack,
`ifdef ALARM_SNOOZE_EN
    input  logic                  snooze,
`endif
    output logic [3:0]            alarm_time_ms_hr,
    output logic [3:0]            alarm_time_ls_hr,
    output logic [3:0]            alarm_time_ms_min,
    output logic [3:0]            alarm_time_ls_min,
    output logic [NUM_ALARMS-1:0] slot_valid,
    output logic [NUM_ALARMS-1:0] alarm_ringing,
    output logic                  alarm,
    output logic                  load_err
);

    typedef struct packed {
        logic [3:0] ms_hr;
        logic [3:0] ls_hr;
        logic [3:0] ms_min;
        logic [3:0] ls_min;
    } bcd_time_t;

`ifdef ALARM_SNOOZE_EN
    typedef enum logic [2:0] {S_IDLE, S_HOLD, S_ARMED, S_RINGING, S_SNOOZED} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_ARMED, S_RINGING} state_t;
`endif

    if (NUM_ALARMS < 1 || NUM_ALARMS > 16 || (1 << SEL_W) < NUM_ALARMS ||
        SNOOZE_MIN < 1 || SNOOZE_MIN > 59) begin : g_bad_params
        $error("alarm_bank: illegal parameter combination");
    end

    function automatic logic time_ok(input bcd_time_t t);
        return (t.ms_hr <= 4'd2) && (t.ls_hr <= 4'd9) &&
               !((t.ms_hr == 4'd2) && (t.ls_hr > 4'd3)) &&
               (t.ms_min <= 4'd5) && (t.ls_min <= 4'd9);
    endfunction

    bcd_time_t             new_time;
    bcd_time_t             cur_time;
    bcd_time_t             rd_time;
    bcd_time_t             time_q  [NUM_ALARMS];
    state_t                state_q [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] sel_dec;
    logic                  sel_in_range;
    logic                  load_ok;
    logic                  load_bad;

    assign new_time = {new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min};
    assign cur_time = {current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min};

    // An out-of-range slot_sel decodes to no slot at all, so load/clear/readback all ignore it.
    always_comb begin
        sel_dec = '0;
        for (int i = 0; i < NUM_ALARMS; i++)
            sel_dec[i] = (int'(slot_sel) == i);
    end

    assign sel_in_range = |sel_dec;
    assign load_ok      = load_new_alarm && !clear_alarm && sel_in_range && time_ok(new_time);
    assign load_bad     = load_new_alarm && !clear_alarm && !(sel_in_range && time_ok(new_time));

    always_comb begin
        rd_time = '0;
        for (int i = 0; i < NUM_ALARMS; i++)
            if (sel_dec[i])
                rd_time = time_q[i];
    end

    assign {alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min} = rd_time;

    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            alarm_ringing[i] = (state_q[i] == S_RINGING);
            slot_valid[i]    = (state_q[i] != S_IDLE);
        end
    end

    assign alarm = |alarm_ringing;

`ifdef ALARM_SNOOZE_EN
    bcd_time_t  snz_q [NUM_ALARMS];
    bcd_time_t  snz_target;
    logic [6:0] snz_min;
    logic [4:0] snz_hr;

    // Shared target for every slot snoozed this cycle: current time + SNOOZE_MIN, wrapping past midnight.
    always_comb begin
        snz_min = 7'(cur_time.ms_min) * 7'd10 + 7'(cur_time.ls_min) + 7'(SNOOZE_MIN);
        snz_hr  = 5'(cur_time.ms_hr) * 5'd10 + 5'(cur_time.ls_hr);
        if (snz_min >= 7'd60) begin
            snz_min = snz_min - 7'd60;
            snz_hr  = (snz_hr >= 5'd23) ? 5'd0 : snz_hr + 5'd1;
        end
        snz_target.ms_hr  = 4'(snz_hr / 5'd10);
        snz_target.ls_hr  = 4'(snz_hr % 5'd10);
        snz_target.ms_min = 4'(snz_min / 7'd10);
        snz_target.ls_min = 4'(snz_min % 7'd10);
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            load_err <= 1'b0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                state_q[i] <= S_IDLE;
                time_q[i]  <= '0;
`ifdef ALARM_SNOOZE_EN
                snz_q[i]   <= '0;
`endif
            end
        end else begin
            load_err <= load_bad;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (clear_alarm && sel_dec[i]) begin
                    state_q[i] <= S_IDLE;
                    time_q[i]  <= '0;
                end else if (load_ok && sel_dec[i]) begin
                    state_q[i] <= S_HOLD;
                    time_q[i]  <= new_time;
                end else begin
                    case (state_q[i])
                        // HOLD waits for the minute to move on so a just-loaded or acked alarm cannot retrigger.
                        S_HOLD:    if (cur_time != time_q[i]) state_q[i] <= S_ARMED;
                        S_ARMED:   if (cur_time == time_q[i]) state_q[i] <= S_RINGING;
                        S_RINGING: begin
                            if (alarm_ack) begin
                                state_q[i] <= S_HOLD;
                            end
`ifdef ALARM_SNOOZE_EN
                            else if (snooze) begin
                                state_q[i] <= S_SNOOZED;
                                snz_q[i]   <= snz_target;
                            end
`endif
                        end
`ifdef ALARM_SNOOZE_EN
                        S_SNOOZED: if (cur_time == snz_q[i]) state_q[i] <= S_RINGING;
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_alarm_bank.sv
// Self-checking bench for alarm_bank: directed vector table, corner-case sequences, randomized run vs. behavioural model.
module tb_alarm_bank;
    localparam int N  = 4;
    localparam int SW = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [15:0]   new_t = '0;
    logic [15:0]   cur_t = '0;
    logic [SW-1:0] slot_sel = '0;
    logic          load_new_alarm = 1'b0;
    logic          clear_alarm = 1'b0;
    logic          alarm_ack = 1'b0;
`ifdef ALARM_SNOOZE_EN
    logic          snooze = 1'b0;
`endif
    logic [3:0]    rd_mh, rd_lh, rd_mm, rd_lm;
    logic [N-1:0]  slot_valid, alarm_ringing;
    logic          alarm, load_err;
    logic [15:0]   rd;

    assign rd = {rd_mh, rd_lh, rd_mm, rd_lm};

    alarm_bank #(.NUM_ALARMS(N), .SEL_W(SW), .SNOOZE_MIN(5)) dut (
        .clock               (clock),
        .reset               (reset),
        .new_alarm_ms_hr     (new_t[15:12]),
        .new_alarm_ls_hr     (new_t[11:8]),
        .new_alarm_ms_min    (new_t[7:4]),
        .new_alarm_ls_min    (new_t[3:0]),
        .slot_sel            (slot_sel),
        .load_new_alarm      (load_new_alarm),
        .clear_alarm         (clear_alarm),
        .current_time_ms_hr  (cur_t[15:12]),
        .current_time_ls_hr  (cur_t[11:8]),
        .current_time_ms_min (cur_t[7:4]),
        .current_time_ls_min (cur_t[3:0]),
        .alarm_ack           (alarm_ack),
`ifdef ALARM_SNOOZE_EN
        .snooze              (snooze),
`endif
        .alarm_time_ms_hr    (rd_mh),
        .alarm_time_ls_hr    (rd_lh),
        .alarm_time_ms_min   (rd_mm),
        .alarm_time_ls_min   (rd_lm),
        .slot_valid          (slot_valid),
        .alarm_ringing       (alarm_ringing),
        .alarm               (alarm),
        .load_err            (load_err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [N-1:0] ring, input logic [N-1:0] valid,
                             input logic err, input logic [15:0] rdx);
        check({tag, " ring"},  alarm_ringing, ring);
        check({tag, " alarm"}, alarm, |ring);
        check({tag, " valid"}, slot_valid, valid);
        check({tag, " err"},   load_err, err);
        check({tag, " rd"},    rd, rdx);
    endtask

    // Drive one cycle of inputs, clock it, and return 1 ns after the edge.
    task automatic step(input bit ld, input bit clr, input bit ack, input int sel,
                        input logic [15:0] lt, input logic [15:0] ct);
        load_new_alarm = ld;
        clear_alarm    = clr;
        alarm_ack      = ack;
        slot_sel       = SW'(sel);
        new_t          = lt;
        cur_t          = ct;
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        bit          ld, clr, ack;
        int          sel;
        logic [15:0] ldt, cur;
        logic [N-1:0] ring, valid;
        bit          err;
        logic [15:0] rdx;
    } vec_t;

    function automatic vec_t mkv(bit ld, bit clr, bit ack, int sel, logic [15:0] ldt, logic [15:0] cur,
                                 logic [N-1:0] ring, logic [N-1:0] valid, bit err, logic [15:0] rdx);
        vec_t v;
        v.ld = ld; v.clr = clr; v.ack = ack; v.sel = sel; v.ldt = ldt; v.cur = cur;
        v.ring = ring; v.valid = valid; v.err = err; v.rdx = rdx;
        return v;
    endfunction

    // Behavioural reference: each slot is a stored time plus "ringing" and "waiting for minute change" flags.
    logic [15:0] m_time [N];
    bit          m_valid [N];
    bit          m_ring  [N];
    bit          m_wait  [N];
    bit          m_err;

    function automatic bit bcd_ok(logic [15:0] t);
        return (t[15:12] <= 4'd2) && (t[11:8] <= 4'd9) && (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9) &&
               ((int'(t[15:12]) * 10 + int'(t[11:8])) <= 23);
    endfunction

    task automatic model_step(input bit ld, input bit clr, input bit ack, input int sel,
                              input logic [15:0] lt, input logic [15:0] ct);
        for (int i = 0; i < N; i++) begin
            if (clr && sel == i) begin
                m_time[i] = '0; m_valid[i] = 0; m_ring[i] = 0; m_wait[i] = 0;
            end else if (ld && !clr && sel == i && bcd_ok(lt)) begin
                m_time[i] = lt; m_valid[i] = 1; m_ring[i] = 0; m_wait[i] = 1;
            end else if (m_ring[i]) begin
                if (ack) begin m_ring[i] = 0; m_wait[i] = 1; end
            end else if (m_valid[i]) begin
                if (m_wait[i]) begin
                    if (ct != m_time[i]) m_wait[i] = 0;
                end else if (ct == m_time[i]) begin
                    m_ring[i] = 1;
                end
            end
        end
        m_err = ld && !clr && !(sel < N && bcd_ok(lt));
    endtask

    vec_t        vecs[$];
    logic [15:0] pool [4];
    logic [N-1:0] exp_ring, exp_valid;
    logic [15:0] exp_rd;
    bit          r_ld, r_clr, r_ack;
    int          r_sel;
    logic [15:0] r_lt, r_ct;

    initial begin
        // Reset state
        #2;
        check_all("reset", '0, '0, 1'b0, 16'h0000);
        @(negedge clock);
        reset = 1'b1;

        vecs.push_back(mkv(1,0,0,0,16'h0730,16'h0729, 4'b0000,4'b0001,0,16'h0730));
        vecs.push_back(mkv(0,0,0,0,16'h0000,16'h0729, 4'b0000,4'b0001,0,16'h0730));
        vecs.push_back(mkv(0,0,0,0,16'h0000,16'h0730, 4'b0001,4'b0001,0,16'h0730));
        vecs.push_back(mkv(0,0,1,0,16'h0000,16'h0730, 4'b0000,4'b0001,0,16'h0730));
        vecs.push_back(mkv(0,0,0,0,16'h0000,16'h0730, 4'b0000,4'b0001,0,16'h0730));
        vecs.push_back(mkv(0,0,0,0,16'h0000,16'h0731, 4'b0000,4'b0001,0,16'h0730));
        vecs.push_back(mkv(0,0,0,0,16'h0000,16'h0730, 4'b0001,4'b0001,0,16'h0730));
        vecs.push_back(mkv(0,0,1,0,16'h0000,16'h0730, 4'b0000,4'b0001,0,16'h0730));
        vecs.push_back(mkv(1,0,0,0,16'h2400,16'h0730, 4'b0000,4'b0001,1,16'h0730));
        vecs.push_back(mkv(0,0,0,0,16'h0000,16'h0730, 4'b0000,4'b0001,0,16'h0730));
        vecs.push_back(mkv(1,0,0,1,16'h1260,16'h0730, 4'b0000,4'b0001,1,16'h0000));
        vecs.push_back(mkv(0,0,0,1,16'h0000,16'h0730, 4'b0000,4'b0001,0,16'h0000));
        vecs.push_back(mkv(1,0,0,5,16'h0800,16'h0730, 4'b0000,4'b0001,1,16'h0000));
        vecs.push_back(mkv(0,0,0,5,16'h0000,16'h0730, 4'b0000,4'b0001,0,16'h0000));
        vecs.push_back(mkv(1,0,0,0,16'h0600,16'h0700, 4'b0000,4'b0001,0,16'h0600));
        vecs.push_back(mkv(1,0,0,3,16'h0600,16'h0700, 4'b0000,4'b1001,0,16'h0600));
        vecs.push_back(mkv(0,0,0,3,16'h0000,16'h0700, 4'b0000,4'b1001,0,16'h0600));
        vecs.push_back(mkv(0,0,0,3,16'h0000,16'h0600, 4'b1001,4'b1001,0,16'h0600));
        vecs.push_back(mkv(0,1,0,3,16'h0000,16'h0600, 4'b0001,4'b0001,0,16'h0000));
        vecs.push_back(mkv(1,1,0,0,16'h0800,16'h0600, 4'b0000,4'b0000,0,16'h0000));
        vecs.push_back(mkv(1,0,0,1,16'h1000,16'h0600, 4'b0000,4'b0010,0,16'h1000));
        vecs.push_back(mkv(1,0,0,2,16'h1001,16'h0600, 4'b0000,4'b0110,0,16'h1001));
        vecs.push_back(mkv(0,0,0,2,16'h0000,16'h1000, 4'b0010,4'b0110,0,16'h1001));
        vecs.push_back(mkv(0,0,1,2,16'h0000,16'h1001, 4'b0100,4'b0110,0,16'h1001));
        vecs.push_back(mkv(1,0,0,2,16'h1200,16'h1001, 4'b0000,4'b0110,0,16'h1200));
        vecs.push_back(mkv(0,1,0,6,16'h0000,16'h1001, 4'b0000,4'b0110,0,16'h0000));

        foreach (vecs[r]) begin
            step(vecs[r].ld, vecs[r].clr, vecs[r].ack, vecs[r].sel, vecs[r].ldt, vecs[r].cur);
            check_all($sformatf("row%0d", r), vecs[r].ring, vecs[r].valid, vecs[r].err, vecs[r].rdx);
        end

        // Loading the current minute must not ring until the minute has changed and come back.
        step(1,0,0,2,16'h0915,16'h0915);
        check_all("same_min load", 4'b0000, 4'b0110, 1'b0, 16'h0915);
        step(0,0,0,2,16'h0000,16'h0915);
        check("same_min hold1", alarm_ringing, 4'b0000);
        step(0,0,0,2,16'h0000,16'h0915);
        check("same_min hold2", alarm_ringing, 4'b0000);
        step(0,0,0,2,16'h0000,16'h0916);
        check("same_min arm", alarm_ringing, 4'b0000);
        step(0,0,0,2,16'h0000,16'h0915);
        check("same_min ring", alarm_ringing, 4'b0100);
        step(0,0,1,2,16'h0000,16'h0915);
        check("same_min ack", alarm_ringing, 4'b0000);

`ifdef ALARM_SNOOZE_EN
        step(1,0,0,0,16'h2358,16'h2357);
        step(0,0,0,0,16'h0000,16'h2357);
        step(0,0,0,0,16'h0000,16'h2358);
        check("snz ring", alarm_ringing, 4'b0001);
        snooze = 1'b1;
        step(0,0,0,0,16'h0000,16'h2358);
        snooze = 1'b0;
        check("snz quiet", alarm_ringing, 4'b0000);
        step(0,0,0,0,16'h0000,16'h2359);
        check("snz 2359", alarm_ringing, 4'b0000);
        step(0,0,0,0,16'h0000,16'h0000);
        check("snz 0000", alarm_ringing, 4'b0000);
        step(0,0,0,0,16'h0000,16'h0002);
        check("snz 0002", alarm_ringing, 4'b0000);
        step(0,0,0,0,16'h0000,16'h0003);
        check("snz 0003", alarm_ringing, 4'b0001);
        step(0,0,1,0,16'h0000,16'h0003);
        check("snz ack", alarm_ringing, 4'b0000);
        check("snz rd", rd, 16'h2358);
`endif

        // Asynchronous reset while slot 1 is ringing.
        step(1,0,0,1,16'h1300,16'h1200);
        step(0,0,0,1,16'h0000,16'h1200);
        step(0,0,0,1,16'h0000,16'h1300);
        check("pre_rst ring", alarm_ringing[1], 1'b1);
        #3;
        reset = 1'b0;
        #1;
        check_all("mid_rst", '0, '0, 1'b0, 16'h0000);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("post_rst rd", rd, 16'h0000);
        check("post_rst ring", alarm_ringing, '0);

        // Randomized run against the behavioural model, starting from the reset state.
        for (int i = 0; i < N; i++) begin
            m_time[i] = '0; m_valid[i] = 0; m_ring[i] = 0; m_wait[i] = 0;
        end
        pool[0] = 16'h0645; pool[1] = 16'h0646; pool[2] = 16'h1159; pool[3] = 16'h2300;
        r_ct = pool[0];
        for (int c = 0; c < 800; c++) begin
            r_ld  = ($urandom_range(0, 9) < 2);
            r_clr = ($urandom_range(0, 11) == 0);
            r_ack = ($urandom_range(0, 6) == 0);
            r_sel = $urandom_range(0, 5);
            r_lt  = ($urandom_range(0, 4) == 0) ? 16'($urandom) : pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 1) == 1) r_ct = pool[$urandom_range(0, 3)];
            model_step(r_ld, r_clr, r_ack, r_sel, r_lt, r_ct);
            step(r_ld, r_clr, r_ack, r_sel, r_lt, r_ct);
            for (int i = 0; i < N; i++) begin
                exp_ring[i]  = m_ring[i];
                exp_valid[i] = m_valid[i];
            end
            exp_rd = (r_sel < N) ? m_time[r_sel] : 16'h0000;
            check_all($sformatf("rand%0d", c), exp_ring, exp_valid, m_err, exp_rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
